// File: rtl/ram_frame_streamer.sv
// ram_frame_streamer
//
// Reads a video frame out of the FPGA-side port of the dual-port frame RAM
// and turns it into an 8-bit pixel stream. Words are fetched in address order
// starting at BASE_ADDR and held in a small word FIFO. Each word is then sent
// as four pixels, least significant byte first. Frames run back-to-back while
// enable is high. A frame that has started always completes.
//
// Ports
//   clk, reset      single clock; synchronous active-high reset
//   enable          level; start or continue streaming frames
//   ram_address     word address to RAM port 2
//   ram_chipselect  read strobe; one word is requested per high cycle
//   ram_readdata    RAM data, valid one cycle after the strobe
//   pix_data        pixel byte
//   pix_valid       pixel valid
//   pix_ready       downstream accept
//   pix_sop         first pixel of the frame (qualified by pix_valid)
//   pix_eop         last pixel of the frame (qualified by pix_valid)
//   busy            high whenever the streamer is not idle
//   frame_done      one-cycle pulse when the eop pixel is accepted
module ram_frame_streamer #(
    parameter int ADDR_W     = 15,
    parameter int BASE_ADDR  = 0,
    parameter int NUM_WORDS  = 25000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    input  logic [31:0]       ram_readdata,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sop,
    output logic              pix_eop,
    output logic              busy,
    output logic              frame_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
    localparam logic [PTR_W:0]    DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] fetch_cnt;
    logic              rd_pending;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_count;

    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] out_cnt;

    logic [PTR_W:0]    occupancy;
    logic              issue;
    logic              last_fetch;
    logic              push;
    logic              pop;
    logic              accept;
    logic [31:0]       head;

    // A read that is still in flight already owns a FIFO slot. This means the
    // return always has room, even if no pop happens that cycle.
    assign occupancy  = fifo_count + {{PTR_W{1'b0}}, rd_pending};
    assign issue      = (state == RUN) && (occupancy < DEPTH);
    assign last_fetch = issue && (fetch_cnt == LAST_WORD);

    assign push   = rd_pending;
    assign accept = pix_valid && pix_ready;
    assign pop    = accept && (byte_idx == 2'd3);
    assign head   = fifo_mem[rd_ptr];

    assign ram_chipselect = issue;
    assign ram_address    = fetch_addr;
    assign busy           = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The FSM decides to stop only when the last word of a
    // frame is fetched, so dropping enable mid-frame never cuts a frame short.
    // In DRAIN, an empty FIFO with nothing in flight means the final word has
    // been popped. That pop happens on the eop accept.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (last_fetch && !enable) state_next = DRAIN;
            DRAIN:   if ((fifo_count == '0) && !rd_pending) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Fetch side. The address goes back to BASE after every final word. If
    // enable is still high, the next frame follows with no gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr <= BASE;
            fetch_cnt  <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= issue;
            if (state == IDLE) begin
                fetch_addr <= BASE;
                fetch_cnt  <= '0;
            end else if (issue) begin
                if (fetch_cnt == LAST_WORD) begin
                    fetch_addr <= BASE;
                    fetch_cnt  <= '0;
                end else begin
                    fetch_addr <= fetch_addr + 1'b1;
                    fetch_cnt  <= fetch_cnt + 1'b1;
                end
            end
        end
    end

    // FIFO storage. When the pointers are reset, anything left in here is
    // simply ignored.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr] <= ram_readdata;
        end
    end

    // FIFO control. A push and a pop in the same cycle leave the count as it
    // is. The pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Output-side position within the frame. This is counted separately from
    // the fetch side, which may already be working on the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx <= 2'd0;
            out_cnt  <= '0;
        end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
                out_cnt <= (out_cnt == LAST_WORD) ? '0 : out_cnt + 1'b1;
            end
        end
    end

    // Pixel presentation. Every field is built from registered state, so it
    // stays stable while the consumer holds off.
    always_comb begin
        pix_data = 8'h00;
        if (pix_valid) begin
            case (byte_idx)
                2'd0:    pix_data = head[7:0];
                2'd1:    pix_data = head[15:8];
                2'd2:    pix_data = head[23:16];
                default: pix_data = head[31:24];
            endcase
        end
    end

    assign pix_valid  = (fifo_count != '0);
    assign pix_sop    = pix_valid && (out_cnt == '0) && (byte_idx == 2'd0);
    assign pix_eop    = pix_valid && (out_cnt == LAST_WORD) && (byte_idx == 2'd3);
    assign frame_done = accept && pix_eop;

endmodule
